// File: rtl/hex_digit_entry.sv
// hex_digit_entry: debounced switch/push-button entry of eight hex digits into a 32-bit word.
// Define HEX_ENTRY_CURSOR_BLINK_EN to blink the cursor digit on the display value array.
`default_nettype none

module hex_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 25000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      sw,
  input  logic            key_load,
  input  logic            key_clear,
  output logic [7:0][4:0] value,
  output logic [31:0]     word,
  output logic [2:0]      cursor,
  output logic            full,
  output logic            done
);

  localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]    BLANK    = 5'h10;

  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    FULL  = 1'b1
  } state_t;

  logic [1:0] raw;
  logic [1:0] press;

  assign raw = {key_clear, key_load};

  // Synchronizers reset low so a key held through reset never looks released.
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          deb_q;
    logic          armed_q;
    logic          press_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q  <= 2'b00;
        cnt_q   <= '0;
        deb_q   <= 1'b1;
        armed_q <= 1'b0;
        press_q <= 1'b0;
      end else begin
        sync_q  <= {sync_q[0], raw[k]};
        press_q <= 1'b0;
        if (sync_q[1]) begin
          armed_q <= 1'b1;
        end
        if (sync_q[1] != deb_q) begin
          if (cnt_q == CNT_LAST) begin
            deb_q   <= sync_q[1];
            cnt_q   <= '0;
            press_q <= deb_q & armed_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end else begin
          cnt_q <= '0;
        end
      end
    end

    assign press[k] = press_q;
  end

  logic load_pulse;
  logic clr_pulse;

  assign load_pulse = press[0];
  assign clr_pulse  = press[1];

  state_t         state_q, state_d;
  logic [7:0][4:0] dig_q, dig_d;
  logic [31:0]    word_q, word_d;
  logic [2:0]     cursor_q, cursor_d;
  logic           full_q, full_d;
  logic           done_q, done_d;

  // Clear has priority over a coincident load.
  always_comb begin
    state_d  = state_q;
    dig_d    = dig_q;
    word_d   = word_q;
    cursor_d = cursor_q;
    full_d   = full_q;
    done_d   = 1'b0;
    if (clr_pulse) begin
      state_d  = ENTRY;
      dig_d    = {8{BLANK}};
      word_d   = '0;
      cursor_d = 3'd7;
      full_d   = 1'b0;
    end else if (load_pulse && (state_q == ENTRY)) begin
      dig_d[cursor_q]                = {1'b0, sw};
      word_d[{cursor_q, 2'b00} +: 4] = sw;
      if (cursor_q == 3'd0) begin
        state_d = FULL;
        full_d  = 1'b1;
        done_d  = 1'b1;
      end else begin
        cursor_d = cursor_q - 3'd1;
      end
    end
  end

`ifdef HEX_ENTRY_CURSOR_BLINK_EN
  localparam int            BW         = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            phase_q, phase_d;
  logic [7:0][4:0] value_q, value_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
    if (clr_pulse) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end
    value_d = dig_d;
    if ((state_d == ENTRY) && phase_d) begin
      value_d[cursor_d] = BLANK;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ENTRY;
      dig_q    <= {8{BLANK}};
      word_q   <= '0;
      cursor_q <= 3'd7;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef HEX_ENTRY_CURSOR_BLINK_EN
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      value_q     <= {8{BLANK}};
`endif
    end else begin
      state_q  <= state_d;
      dig_q    <= dig_d;
      word_q   <= word_d;
      cursor_q <= cursor_d;
      full_q   <= full_d;
      done_q   <= done_d;
`ifdef HEX_ENTRY_CURSOR_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      value_q     <= value_d;
`endif
    end
  end

`ifdef HEX_ENTRY_CURSOR_BLINK_EN
  assign value = value_q;
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_CYCLES;
  assign value        = dig_q;
`endif

  assign word   = word_q;
  assign cursor = cursor_q;
  assign full   = full_q;
  assign done   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_hex_digit_entry.sv
// tb_hex_digit_entry: directed and randomized key stimulus checked every cycle against a
// behavioural model of the debounce filter and the digit-entry rules.
`default_nettype none

module tb_hex_digit_entry;

  localparam int DEB   = 4;
  localparam int BLINK = 8;
  localparam int LAT   = 3;  // samples from accepted run to FSM action

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      sw;
  logic            key_load;
  logic            key_clear;
  logic [7:0][4:0] value;
  logic [31:0]     word;
  logic [2:0]      cursor;
  logic            full;
  logic            done;

  int checks = 0;
  int errors = 0;

  hex_digit_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLINK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .key_load (key_load),
    .key_clear(key_clear),
    .value    (value),
    .word     (word),
    .cursor   (cursor),
    .full     (full),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model: digits (-1 = blank), count entered, filtered levels, pending actions.
  int          m_dig[8];
  int          m_filled;
  logic        m_done;
  logic [31:0] hist_ld, hist_cl;
  logic        lvl_ld, lvl_cl;
  int          due_ld[$];
  int          due_cl[$];
  int          sample_no;
  int          done_seen;

  task automatic model_init();
    for (int i = 0; i < 8; i++) m_dig[i] = -1;
    m_filled  = 0;
    m_done    = 1'b0;
    hist_ld   = '1;
    hist_cl   = '1;
    lvl_ld    = 1'b1;
    lvl_cl    = 1'b1;
    due_ld    = {};
    due_cl    = {};
    sample_no = 0;
  endtask

  // A level is accepted once the last DEB samples all disagree with the current level.
  function automatic logic filt(input logic [31:0] hist, input logic lvl);
    logic [31:0] mask;
    mask = (32'd1 << DEB) - 32'd1;
    if (lvl && ((hist & mask) == 32'd0)) return 1'b0;
    if (!lvl && ((hist & mask) == mask)) return 1'b1;
    return lvl;
  endfunction

  task automatic model_sample(input logic ld, input logic cl, input logic [3:0] s);
    logic do_ld, do_cl, nl;
    sample_no++;
    hist_ld = {hist_ld[30:0], ld};
    hist_cl = {hist_cl[30:0], cl};
    do_ld = 1'b0;
    do_cl = 1'b0;
    if (due_ld.size() > 0 && due_ld[0] == sample_no) begin
      do_ld = 1'b1;
      void'(due_ld.pop_front());
    end
    if (due_cl.size() > 0 && due_cl[0] == sample_no) begin
      do_cl = 1'b1;
      void'(due_cl.pop_front());
    end
    m_done = 1'b0;
    if (do_cl) begin
      for (int i = 0; i < 8; i++) m_dig[i] = -1;
      m_filled = 0;
    end else if (do_ld && m_filled < 8) begin
      m_dig[7 - m_filled] = int'(s);
      m_filled++;
      if (m_filled == 8) m_done = 1'b1;
    end
    nl = filt(hist_ld, lvl_ld);
    if (lvl_ld && !nl) due_ld.push_back(sample_no + LAT);
    lvl_ld = nl;
    nl = filt(hist_cl, lvl_cl);
    if (lvl_cl && !nl) due_cl.push_back(sample_no + LAT);
    lvl_cl = nl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] we;
    logic [4:0]  ve;
    we = '0;
    for (int i = 0; i < 8; i++) begin
      if (m_dig[i] < 0) begin
        ve = 5'h10;
      end else begin
        ve = {1'b0, 4'(m_dig[i])};
        we[i*4 +: 4] = 4'(m_dig[i]);
      end
      chk($sformatf("value[%0d]", i), 32'(value[i]), 32'(ve));
    end
    chk("word", word, we);
    chk("cursor", 32'(cursor), (m_filled < 8) ? 32'(7 - m_filled) : 32'd0);
    chk("full", 32'(full), (m_filled == 8) ? 32'd1 : 32'd0);
    chk("done", 32'(done), 32'(m_done));
    if (done === 1'b1) done_seen++;
  endtask

  task automatic step(input logic ld, input logic cl, input logic [3:0] s);
    key_load  = ld;
    key_clear = cl;
    sw        = s;
    @(posedge clk);
    model_sample(ld, cl, s);
    #1;
    check_all();
  endtask

  task automatic press_load(input logic [3:0] s);
    repeat (10) step(1'b0, 1'b1, s);
    repeat (10) step(1'b1, 1'b1, s);
  endtask

  task automatic press_clear();
    repeat (10) step(1'b1, 1'b0, 4'h0);
    repeat (10) step(1'b1, 1'b1, 4'h0);
  endtask

  initial begin
    logic lv, lvl_l, lvl_c;
    int   run_l, run_c;

    rst       = 1'b1;
    key_load  = 1'b1;
    key_clear = 1'b1;
    sw        = 4'h0;
    model_init();
    done_seen = 0;
    #2 rst = 1'b0;
    #10;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    repeat (20) step(1'b1, 1'b1, 4'h0);

    // Fill all eight digits, first entered is most significant.
    done_seen = 0;
    for (int d = 1; d <= 8; d++) press_load(4'(d));
    chk("fill_word", word, 32'h12345678);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_cursor", 32'(cursor), 32'd0);
    press_load(4'hF);
    chk("ninth_word", word, 32'h12345678);
    chk("done_count", 32'(done_seen), 32'd1);

    // Chatter shorter than the debounce window, then a stable press.
    press_clear();
    lv = 1'b0;
    for (int n = 0; n < 7; n++) begin
      repeat ($urandom_range(1, 2)) step(lv, 1'b1, 4'h9);
      lv = ~lv;
    end
    repeat (10) step(1'b0, 1'b1, 4'h9);
    repeat (10) step(1'b1, 1'b1, 4'h9);
    chk("chatter_v7", 32'(value[7]), 32'h09);
    chk("chatter_v6", 32'(value[6]), 32'h10);
    chk("chatter_cursor", 32'(cursor), 32'd6);

    // Clear after partial entry, then restart at the top digit.
    press_clear();
    press_load(4'hA);
    press_load(4'hB);
    press_load(4'hC);
    press_clear();
    chk("clr_word", word, 32'h0);
    chk("clr_cursor", 32'(cursor), 32'd7);
    press_load(4'hD);
    chk("restart_v7", 32'(value[7]), 32'h0D);

    // Simultaneous load and clear: clear wins.
    press_load(4'h5);
    repeat (10) step(1'b0, 1'b0, 4'h6);
    repeat (10) step(1'b1, 1'b1, 4'h6);
    chk("both_cursor", 32'(cursor), 32'd7);
    chk("both_word", word, 32'h0);

    // Random key waveforms with random switch values every cycle.
    lvl_l = 1'b1;
    lvl_c = 1'b1;
    run_l = 0;
    run_c = 50;
    for (int c = 0; c < 800; c++) begin
      if (run_l == 0) begin
        lvl_l = ~lvl_l;
        run_l = $urandom_range(1, 8);
      end
      if (run_c == 0) begin
        lvl_c = ~lvl_c;
        run_c = lvl_c ? $urandom_range(60, 160) : $urandom_range(2, 7);
      end
      step(lvl_l, lvl_c, 4'($urandom_range(0, 15)));
      run_l--;
      run_c--;
    end
    repeat (20) step(1'b1, 1'b1, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
